// File: rtl/rob_param_if.sv
// Dispatch / writeback / retire bundle of the parametrised reorder buffer.
// The ROB attaches through the slave modport; its environment through master.
interface rob_param_if #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned XLEN  = 32
);
  logic             alloc_valid;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic [2:0]       alloc_kind;
  logic [XLEN-1:0]  alloc_pc;
  logic [4:0]       alloc_dest;
  logic             alloc_done;
  logic [XLEN-1:0]  alloc_value;
  logic             alloc_pred_taken;
  logic [XLEN-1:0]  alloc_pred_target;

  logic             wb0_valid;
  logic [TAG_W-1:0] wb0_tag;
  logic [XLEN-1:0]  wb0_value;
  logic             wb0_taken;
  logic [XLEN-1:0]  wb0_target;
  logic             wb1_valid;
  logic [TAG_W-1:0] wb1_tag;
  logic [XLEN-1:0]  wb1_value;

  logic [TAG_W-1:0] q1_tag;
  logic [TAG_W-1:0] q2_tag;
  logic             q1_ready;
  logic             q2_ready;
  logic [XLEN-1:0]  q1_value;
  logic [XLEN-1:0]  q2_value;

  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic [4:0]       commit_dest;
  logic [XLEN-1:0]  commit_value;
  logic             st_commit_req;
  logic             st_commit_ack;
  logic             bp_update;
  logic [XLEN-1:0]  bp_pc;
  logic             bp_taken;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [TAG_W:0]   count;
  logic             empty;

  modport master (
    output alloc_valid, alloc_kind, alloc_pc, alloc_dest, alloc_done, alloc_value,
           alloc_pred_taken, alloc_pred_target,
           wb0_valid, wb0_tag, wb0_value, wb0_taken, wb0_target,
           wb1_valid, wb1_tag, wb1_value, q1_tag, q2_tag, st_commit_ack,
    input  alloc_ready, alloc_tag, q1_ready, q2_ready, q1_value, q2_value,
           commit_valid, commit_tag, commit_dest, commit_value, st_commit_req,
           bp_update, bp_pc, bp_taken, redirect_valid, redirect_pc, count, empty
  );

  modport slave (
    input  alloc_valid, alloc_kind, alloc_pc, alloc_dest, alloc_done, alloc_value,
           alloc_pred_taken, alloc_pred_target,
           wb0_valid, wb0_tag, wb0_value, wb0_taken, wb0_target,
           wb1_valid, wb1_tag, wb1_value, q1_tag, q2_tag, st_commit_ack,
    output alloc_ready, alloc_tag, q1_ready, q2_ready, q1_value, q2_value,
           commit_valid, commit_tag, commit_dest, commit_value, st_commit_req,
           bp_update, bp_pc, bp_taken, redirect_valid, redirect_pc, count, empty
  );
endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, two writeback channels with
// operand bypass, single in-order retire with store handshake and branch recovery.
module rob_param #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned XLEN  = 32
) (
  input logic        clk,
  input logic        rst,
  input logic        rdy,
  input logic        flush_in,
  rob_param_if.slave bus
);
  localparam int unsigned CNT_W = TAG_W + 1;

  typedef enum logic [2:0] {
    K_ALU    = 3'd0,
    K_LOAD   = 3'd1,
    K_STORE  = 3'd2,
    K_BRANCH = 3'd3,
    K_JAL    = 3'd4,
    K_JALR   = 3'd5
  } kind_e;

  typedef struct packed {
    kind_e            kind;
    logic [XLEN-1:0]  pc;
    logic [4:0]       dest;
    logic [XLEN-1:0]  value;
    logic             taken;
    logic [XLEN-1:0]  target;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t hd;
  logic   full;
  logic   alloc_fire;
  logic   commit_fire;
  logic   mispredict;
  logic   wb0_live;
  logic   wb1_live;

  assign hd         = ent_q[head_q];
  assign full       = (count_q == CNT_W'(DEPTH));
  assign alloc_fire = bus.alloc_valid && !full;

  // A tag is live when its distance from head is below the occupancy.
  assign wb0_live = {1'b0, TAG_W'(bus.wb0_tag - head_q)} < count_q;
  assign wb1_live = {1'b0, TAG_W'(bus.wb1_tag - head_q)} < count_q;

  assign bus.alloc_ready = !full;
  assign bus.alloc_tag   = tail_q;
  assign bus.count       = count_q;
  assign bus.empty       = (count_q == '0);

  // Operand lookup: wb0 bypass beats wb1 bypass beats stored entry.
  always_comb begin
    bus.q1_ready = ready_q[bus.q1_tag];
    bus.q1_value = ent_q[bus.q1_tag].value;
    if (bus.wb0_valid && bus.wb0_tag == bus.q1_tag) begin
      bus.q1_ready = 1'b1;
      bus.q1_value = bus.wb0_value;
    end else if (bus.wb1_valid && bus.wb1_tag == bus.q1_tag) begin
      bus.q1_ready = 1'b1;
      bus.q1_value = bus.wb1_value;
    end
    bus.q2_ready = ready_q[bus.q2_tag];
    bus.q2_value = ent_q[bus.q2_tag].value;
    if (bus.wb0_valid && bus.wb0_tag == bus.q2_tag) begin
      bus.q2_ready = 1'b1;
      bus.q2_value = bus.wb0_value;
    end else if (bus.wb1_valid && bus.wb1_tag == bus.q2_tag) begin
      bus.q2_ready = 1'b1;
      bus.q2_value = bus.wb1_value;
    end
  end

  // Retire decision for the head entry.
  always_comb begin
    commit_fire        = 1'b0;
    mispredict         = 1'b0;
    bus.commit_tag     = head_q;
    bus.commit_dest    = '0;
    bus.commit_value   = '0;
    bus.st_commit_req  = 1'b0;
    bus.bp_update      = 1'b0;
    bus.bp_pc          = '0;
    bus.bp_taken       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    if (rdy && !flush_in && count_q != '0 && ready_q[head_q]) begin
      case (hd.kind)
        K_STORE: begin
          bus.st_commit_req = 1'b1;
          commit_fire       = bus.st_commit_ack;
          bus.commit_dest   = hd.dest;
          bus.commit_value  = hd.value;
        end
        K_BRANCH: begin
          commit_fire   = 1'b1;
          bus.bp_update = 1'b1;
          bus.bp_pc     = hd.pc;
          bus.bp_taken  = hd.taken;
          mispredict    = (hd.taken != hd.pred_taken) ||
                          (hd.taken && hd.target != hd.pred_target);
        end
        K_JALR: begin
          commit_fire      = 1'b1;
          bus.commit_dest  = hd.dest;
          bus.commit_value = hd.value;
          mispredict       = (hd.target != hd.pred_target);
        end
        default: begin
          commit_fire      = 1'b1;
          bus.commit_dest  = hd.dest;
          bus.commit_value = hd.value;
        end
      endcase
      bus.redirect_valid = mispredict;
      // JALR always jumps, so its resolved target is the fetch PC.
      bus.redirect_pc    = (hd.kind == K_JALR || hd.taken) ? hd.target : hd.pc + XLEN'(4);
    end
    bus.commit_valid = commit_fire;
  end

  // Next-state for pointers, occupancy and entry storage.
  always_comb begin
    ent_d   = ent_q;
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (!rdy) begin
      // frozen
    end else if (flush_in || mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ready_d = '0;
    end else begin
      if (alloc_fire) begin
        ent_d[tail_q].kind        = kind_e'(bus.alloc_kind);
        ent_d[tail_q].pc          = bus.alloc_pc;
        ent_d[tail_q].dest        = bus.alloc_dest;
        ent_d[tail_q].value       = bus.alloc_value;
        ent_d[tail_q].taken       = 1'b0;
        ent_d[tail_q].target      = '0;
        ent_d[tail_q].pred_taken  = bus.alloc_pred_taken;
        ent_d[tail_q].pred_target = bus.alloc_pred_target;
        ready_d[tail_q]           = bus.alloc_done;
        tail_d                    = tail_q + TAG_W'(1);
      end
      if (bus.wb1_valid && wb1_live) begin
        ent_d[bus.wb1_tag].value = bus.wb1_value;
        ready_d[bus.wb1_tag]     = 1'b1;
      end
      // wb0 applied after wb1 so it wins a same-tag collision.
      if (bus.wb0_valid && wb0_live) begin
        ent_d[bus.wb0_tag].value  = bus.wb0_value;
        ent_d[bus.wb0_tag].taken  = bus.wb0_taken;
        ent_d[bus.wb0_tag].target = bus.wb0_target;
        ready_d[bus.wb0_tag]      = 1'b1;
      end
      if (commit_fire) begin
        ready_d[head_q] = 1'b0;
        head_d          = head_q + TAG_W'(1);
      end
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // Payload is qualified by ready_q, so it needs no reset.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end
endmodule

// File: tb/tb_rob_param.sv
// Scoreboard bench for rob_param: expected retirements are queued at dispatch
// and popped whenever the ROB reports a commit.
module tb_rob_param;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned XLEN  = 32;

  localparam logic [2:0] K_ALU = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2,
                         K_BRANCH = 3'd3, K_JALR = 3'd5;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [4:0]       dest;
    logic [XLEN-1:0]  value;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  logic flush_in = 1'b0;

  rob_param_if #(.TAG_W(TAG_W), .XLEN(XLEN)) bus ();

  rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .flush_in (flush_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  exp_t             sb[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic [TAG_W-1:0] tl = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alloc_valid = 0; bus.alloc_kind = '0; bus.alloc_pc = '0; bus.alloc_dest = '0;
    bus.alloc_done = 0; bus.alloc_value = '0; bus.alloc_pred_taken = 0; bus.alloc_pred_target = '0;
    bus.wb0_valid = 0; bus.wb0_tag = '0; bus.wb0_value = '0; bus.wb0_taken = 0; bus.wb0_target = '0;
    bus.wb1_valid = 0; bus.wb1_tag = '0; bus.wb1_value = '0;
    bus.q1_tag = '0; bus.q2_tag = '0; bus.st_commit_ack = 0;
  endtask

  // Sample point: mid-cycle; any commit is checked against the scoreboard.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (bus.commit_valid) begin
      if (sb.size() == 0) check_eq("commit_unexpected", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check_eq("commit_tag", 64'(bus.commit_tag), 64'(e.tag));
        check_eq("commit_dest", 64'(bus.commit_dest), 64'(e.dest));
        if (e.dest != 0) check_eq("commit_value", 64'(bus.commit_value), 64'(e.value));
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic alloc(input logic [2:0] kind, input logic [XLEN-1:0] pc, input logic [4:0] dest,
                       input logic done, input logic [XLEN-1:0] value, input logic pt,
                       input logic [XLEN-1:0] ptgt, input bit push);
    bus.alloc_valid = 1; bus.alloc_kind = kind; bus.alloc_pc = pc; bus.alloc_dest = dest;
    bus.alloc_done = done; bus.alloc_value = value; bus.alloc_pred_taken = pt;
    bus.alloc_pred_target = ptgt;
    sample();
    check_eq("alloc_tag", 64'(bus.alloc_tag), 64'(tl));
    if (push) sb.push_back('{tl, dest, value});
    adv();
    bus.alloc_valid = 0;
    tl = tl + TAG_W'(1);
  endtask

  task automatic wb0(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v, input logic tk,
                     input logic [XLEN-1:0] tgt);
    bus.wb0_valid = 1; bus.wb0_tag = t; bus.wb0_value = v; bus.wb0_taken = tk; bus.wb0_target = tgt;
    cyc();
    bus.wb0_valid = 0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) cyc();
    if (sb.size() != 0) check_eq("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [TAG_W-1:0] pend[$];
    logic [TAG_W-1:0] t;
    logic [XLEN-1:0]  vals [DEPTH];
    int               k;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    check_eq("rst_empty", 64'(bus.empty), 64'd1);
    check_eq("rst_count", 64'(bus.count), 64'd0);
    check_eq("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    check_eq("rst_redirect", 64'(bus.redirect_valid), 64'd0);
    check_eq("rst_st_req", 64'(bus.st_commit_req), 64'd0);
    rst = 1; rdy = 1;
    adv();

    // Fill all entries, nothing retires; then overflow attempt and flush.
    for (int i = 0; i < DEPTH; i++) alloc(K_ALU, XLEN'(i * 4), 5'd1, 1'b0, '0, 1'b0, '0, 1'b0);
    bus.alloc_valid = 1;
    sample();
    check_eq("full_alloc_ready", 64'(bus.alloc_ready), 64'd0);
    check_eq("full_count", 64'(bus.count), 64'(DEPTH));
    check_eq("full_tail_wrap", 64'(bus.alloc_tag), 64'd0);
    adv();
    bus.alloc_valid = 0;
    flush_in = 1;
    sample();
    check_eq("full_hold_count", 64'(bus.count), 64'(DEPTH));
    check_eq("flush_no_commit", 64'(bus.commit_valid), 64'd0);
    adv();
    flush_in = 0;
    tl = '0;
    sample();
    check_eq("flush_count", 64'(bus.count), 64'd0);
    check_eq("flush_empty", 64'(bus.empty), 64'd1);
    check_eq("flush_tail", 64'(bus.alloc_tag), 64'd0);
    adv();

    // Bypass, out-of-order writeback and same-tag collision.
    alloc(K_ALU, 32'h0, 5'd1, 1'b0, 32'h10, 1'b0, '0, 1'b1);
    alloc(K_ALU, 32'h4, 5'd2, 1'b0, 32'h11, 1'b0, '0, 1'b1);
    alloc(K_ALU, 32'h8, 5'd3, 1'b0, 32'h1, 1'b0, '0, 1'b1);
    alloc(K_ALU, 32'hc, 5'd5, 1'b0, 32'hDEAD, 1'b0, '0, 1'b1);
    bus.wb0_valid = 1; bus.wb0_tag = 4'd3; bus.wb0_value = 32'hDEAD;
    bus.q1_tag = 4'd3; bus.q2_tag = 4'd2;
    sample();
    check_eq("byp_q1_ready", 64'(bus.q1_ready), 64'd1);
    check_eq("byp_q1_value", 64'(bus.q1_value), 64'hDEAD);
    check_eq("byp_q2_notready", 64'(bus.q2_ready), 64'd0);
    adv();
    bus.wb0_valid = 0;
    sample();
    check_eq("stored_q1_ready", 64'(bus.q1_ready), 64'd1);
    check_eq("stored_q1_value", 64'(bus.q1_value), 64'hDEAD);
    adv();
    bus.wb1_valid = 1; bus.wb1_tag = 4'd0; bus.wb1_value = 32'h10;
    bus.wb0_valid = 1; bus.wb0_tag = 4'd1; bus.wb0_value = 32'h11;
    bus.q1_tag = 4'd0; bus.q2_tag = 4'd1;
    sample();
    check_eq("byp_wb1_value", 64'(bus.q1_value), 64'h10);
    check_eq("byp_wb0_value", 64'(bus.q2_value), 64'h11);
    adv();
    bus.wb0_valid = 0; bus.wb1_valid = 0;
    cyc();
    cyc();
    sample();
    check_eq("stall_commit", 64'(bus.commit_valid), 64'd0);
    check_eq("stall_count", 64'(bus.count), 64'd2);
    adv();
    bus.wb0_valid = 1; bus.wb0_tag = 4'd2; bus.wb0_value = 32'h1;
    bus.wb1_valid = 1; bus.wb1_tag = 4'd2; bus.wb1_value = 32'h2;
    bus.q1_tag = 4'd2;
    sample();
    check_eq("collide_byp", 64'(bus.q1_value), 64'h1);
    adv();
    bus.wb0_valid = 0; bus.wb1_valid = 0;
    drain(10);
    sample();
    check_eq("drain_empty", 64'(bus.empty), 64'd1);
    adv();

    // Writeback to a dead tag must not mark it ready once allocated.
    wb0(4'd5, 32'h55, 1'b0, '0);
    alloc(K_LOAD, 32'h10, 5'd6, 1'b0, 32'h66, 1'b0, '0, 1'b1);
    alloc(K_ALU, 32'h14, 5'd7, 1'b0, 32'h77, 1'b0, '0, 1'b1);
    bus.q1_tag = 4'd5;
    sample();
    check_eq("dead_wb_ignored", 64'(bus.q1_ready), 64'd0);
    adv();
    bus.wb1_valid = 1; bus.wb1_tag = 4'd4; bus.wb1_value = 32'h66;
    bus.wb0_valid = 1; bus.wb0_tag = 4'd5; bus.wb0_value = 32'h77;
    cyc();
    bus.wb0_valid = 0; bus.wb1_valid = 0;
    drain(10);

    // Store handshake at head.
    alloc(K_STORE, 32'h20, 5'd0, 1'b0, '0, 1'b0, '0, 1'b1);
    bus.st_commit_ack = 1;
    sample();
    check_eq("ack_no_req", 64'(bus.commit_valid), 64'd0);
    adv();
    bus.st_commit_ack = 0;
    bus.wb1_valid = 1; bus.wb1_tag = 4'd6; bus.wb1_value = 32'h1000;
    cyc();
    bus.wb1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("st_req_wait", 64'(bus.st_commit_req), 64'd1);
      check_eq("st_no_commit", 64'(bus.commit_valid), 64'd0);
      check_eq("st_head", 64'(bus.commit_tag), 64'd6);
      check_eq("st_count", 64'(bus.count), 64'd1);
      adv();
    end
    bus.st_commit_ack = 1;
    sample();
    check_eq("st_commit", 64'(bus.commit_valid), 64'd1);
    adv();
    bus.st_commit_ack = 0;
    sample();
    check_eq("st_count_after", 64'(bus.count), 64'd0);
    adv();

    // Branch mispredict with four ready younger entries.
    alloc(K_BRANCH, 32'h100, 5'd0, 1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) alloc(K_ALU, 32'h104 + XLEN'(i * 4), 5'd9, 1'b1, 32'h9, 1'b0, '0, 1'b0);
    wb0(4'd7, '0, 1'b1, 32'h200);
    bus.alloc_valid = 1; bus.alloc_kind = K_ALU;
    sample();
    check_eq("br_redirect", 64'(bus.redirect_valid), 64'd1);
    check_eq("br_redirect_pc", 64'(bus.redirect_pc), 64'h200);
    check_eq("br_bp_update", 64'(bus.bp_update), 64'd1);
    check_eq("br_bp_taken", 64'(bus.bp_taken), 64'd1);
    check_eq("br_bp_pc", 64'(bus.bp_pc), 64'h100);
    check_eq("br_commit", 64'(bus.commit_valid), 64'd1);
    adv();
    bus.alloc_valid = 0;
    tl = '0;
    sample();
    check_eq("br_count", 64'(bus.count), 64'd0);
    check_eq("br_empty", 64'(bus.empty), 64'd1);
    check_eq("br_tail", 64'(bus.alloc_tag), 64'd0);
    adv();

    // Correctly predicted not-taken branch.
    alloc(K_BRANCH, 32'h180, 5'd0, 1'b0, '0, 1'b0, '0, 1'b1);
    wb0(4'd0, '0, 1'b0, 32'h999);
    sample();
    check_eq("brok_bp_update", 64'(bus.bp_update), 64'd1);
    check_eq("brok_bp_taken", 64'(bus.bp_taken), 64'd0);
    check_eq("brok_no_redirect", 64'(bus.redirect_valid), 64'd0);
    adv();

    // JALR mispredict, then a correct JALR.
    alloc(K_JALR, 32'h300, 5'd1, 1'b0, 32'h304, 1'b1, 32'h40, 1'b1);
    alloc(K_ALU, 32'h44, 5'd4, 1'b1, 32'h4, 1'b0, '0, 1'b0);
    wb0(4'd1, 32'h304, 1'b1, 32'h44);
    sample();
    check_eq("jalr_redirect", 64'(bus.redirect_valid), 64'd1);
    check_eq("jalr_redirect_pc", 64'(bus.redirect_pc), 64'h44);
    check_eq("jalr_dest", 64'(bus.commit_dest), 64'd1);
    adv();
    tl = '0;
    sample();
    check_eq("jalr_count", 64'(bus.count), 64'd0);
    adv();
    alloc(K_JALR, 32'h400, 5'd2, 1'b0, 32'h404, 1'b1, 32'h80, 1'b1);
    wb0(4'd0, 32'h404, 1'b1, 32'h80);
    sample();
    check_eq("jalr_ok_redirect", 64'(bus.redirect_valid), 64'd0);
    check_eq("jalr_ok_commit", 64'(bus.commit_valid), 64'd1);
    adv();

    // rdy low freezes everything, including writeback and allocation.
    alloc(K_ALU, 32'h500, 5'd3, 1'b0, 32'h33, 1'b0, '0, 1'b1);
    rdy = 0;
    bus.alloc_valid = 1;
    bus.wb0_valid = 1; bus.wb0_tag = 4'd1; bus.wb0_value = 32'h33;
    for (int i = 0; i < 2; i++) begin
      sample();
      check_eq("frz_no_commit", 64'(bus.commit_valid), 64'd0);
      adv();
    end
    idle_inputs();
    rdy = 1;
    bus.q1_tag = 4'd1;
    sample();
    check_eq("frz_count", 64'(bus.count), 64'd1);
    check_eq("frz_tail", 64'(bus.alloc_tag), 64'd2);
    check_eq("frz_not_ready", 64'(bus.q1_ready), 64'd0);
    adv();
    wb0(4'd1, 32'h33, 1'b0, '0);
    drain(10);

    // Random out-of-order completion through both channels.
    for (int i = 0; i < 8; i++) begin
      t = tl;
      vals[t] = $urandom;
      k = int'($urandom_range(1, 0));
      alloc((k != 0) ? K_LOAD : K_ALU, XLEN'(i * 4), 5'($urandom_range(31, 1)), 1'(k), vals[t],
            1'b0, '0, 1'b1);
      if (k == 0) pend.push_back(t);
    end
    while (pend.size() != 0) begin
      k = int'($urandom_range(pend.size() - 1, 0));
      t = pend[k];
      pend.delete(k);
      if ($urandom_range(1, 0) != 0) begin
        bus.wb0_valid = 1; bus.wb0_tag = t; bus.wb0_value = vals[t];
      end else begin
        bus.wb1_valid = 1; bus.wb1_tag = t; bus.wb1_value = vals[t];
      end
      cyc();
      bus.wb0_valid = 0; bus.wb1_valid = 0;
    end
    drain(20);

    // Reset mid-operation drops live entries.
    alloc(K_ALU, 32'h600, 5'd8, 1'b0, '0, 1'b0, '0, 1'b0);
    rst = 0;
    #2;
    check_eq("midrst_count", 64'(bus.count), 64'd0);
    check_eq("midrst_empty", 64'(bus.empty), 64'd1);
    adv();
    rst = 1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer, successor to the fixed 16-entry ROB.
- Sits between dispatch (instruction queue/decoder), the execution writeback paths (RS/ALU channel and SLB/load channel), the register file/rename table and the branch predictor.
- Allocates in order, accepts two independent writeback channels, forwards operands with same-cycle bypass, and retires one entry per cycle.
- Retirement covers: store-commit handshake with the SLB, and branch/JALR target-mismatch recovery.

Parameters:
- DEPTH, 16, number of entries; power of two, 4..64.
- TAG_W, 4, tag width; must equal log2(DEPTH).
- XLEN, 32, data/PC width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low freezes all state.
- flush_in  in  1  external clear.
- alloc_valid  in  1  dispatch request.
- alloc_ready  out  1  = !full.
- alloc_tag  out  TAG_W  tail index given to the dispatching instruction.
- alloc_kind  in  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 JALR.
- alloc_pc  in  XLEN  instruction PC.
- alloc_dest  in  5  rd (0 = none).
- alloc_done  in  1  entry ready at issue (LUI/AUIPC/JAL).
- alloc_value  in  XLEN  value when alloc_done.
- alloc_pred_taken  in  1  predictor direction.
- alloc_pred_target  in  XLEN  predicted target.
- wb0_valid, wb0_tag, wb0_value, wb0_taken, wb0_target  in  1/TAG_W/XLEN/1/XLEN  RS/ALU channel.
- wb1_valid, wb1_tag, wb1_value  in  1/TAG_W/XLEN  SLB channel (loads; stores mark address ready).
- q1_tag, q2_tag  in  TAG_W  operand lookup.
- q1_ready, q2_ready  out  1  lookup hit.
- q1_value, q2_value  out  XLEN  lookup data.
- commit_valid  out  1  head retires this cycle.
- commit_tag  out  TAG_W  head index.
- commit_dest  out  5  rd written.
- commit_value  out  XLEN  rd data.
- st_commit_req  out  1  head is a ready store.
- st_commit_ack  in  1  SLB has accepted the store.
- bp_update  out  1  conditional branch retired.
- bp_pc  out  XLEN  retired branch PC.
- bp_taken  out  1  retired branch outcome.
- redirect_valid  out  1  mispredict; pulse the cycle the flush is issued.
- redirect_pc  out  XLEN  correct fetch PC.
- count  out  TAG_W+1  occupancy.
- empty  out  1  count == 0.

Behaviour:
- State:
  - head, tail (TAG_W, wrap modulo DEPTH); count (TAG_W+1).
  - Per entry: kind, pc, dest, value, ready, taken, target, pred_taken, pred_target.
- Reset (rst low, async): head = tail = count = 0; all ready = 0. All outputs 0 except alloc_ready = 1 and empty = 1.
- Priority per edge: rst > !rdy (hold) > flush_in or mispredict flush > normal operation.
- Allocate when alloc_valid && alloc_ready:
  - Write entry[tail]; ready = alloc_done; tail += 1.
  - alloc_tag is combinational = tail.
- Writeback on wbN_valid:
  - Sets value and ready; wb0 also sets taken and target.
  - Writeback to an entry outside the [head, tail) live window is ignored.
  - wb0 and wb1 to the same tag in one cycle: wb0 wins.
- Lookup: qN_ready = entry ready, OR wb0/wb1 valid with a matching tag this cycle. The bypassed value takes wb0 over wb1 over the stored value.
- Commit is combinational from head, evaluated only when count != 0, rdy = 1 and entry[head].ready.
  - ALU/LOAD/JAL:
    - commit_valid = 1; commit_dest, commit_value from the entry.
    - head += 1 next edge.
  - STORE:
    - st_commit_req = 1; commit_valid = 1 only in a cycle with st_commit_ack.
    - Head holds until ack; ack with no request is ignored.
  - BRANCH:
    - bp_update = 1, bp_taken = taken.
    - Mispredict if taken != pred_taken, or (taken and target != pred_target).
    - commit_dest = 0.
  - JALR:
    - Writes rd like ALU.
    - Mispredict if target != pred_target.
  - Mispredict:
    - redirect_valid = 1; redirect_pc = taken ? target : pc+4.
    - Entry still retires (commit_valid = 1).
    - Next edge: head = tail = count = 0, all ready cleared; the same-cycle allocation is discarded.
- count next = count + alloc_fire − commit_fire. Simultaneous alloc and commit when full is not allowed: alloc_ready does not look ahead.
- flush_in: same reset of pointers and ready bits; retire and alloc in that cycle are suppressed (no outputs asserted).
- A reset asserted mid-operation drops all entries without commit.
- full = (count == DEPTH).

Test Plan:
- Reset, then 16 allocs (DEPTH = 16) with no writeback -> alloc_ready = 0 after 16th, count = 16, tags 0..15; tail wraps to 0.
- Alloc ALU tag 3 (dest 5); wb0 tag 3 value 0xDEAD in cycle N with q1_tag = 3 -> q1_ready = 1, q1_value = 0xDEAD in cycle N. Commit at head: commit_dest = 5, commit_value = 0xDEAD.
- Store at head ready; ack held low 3 cycles -> st_commit_req = 1 for 3 cycles, head fixed, commit_valid = 0. Ack -> commit_valid = 1, count decrements.
- Branch pc 0x100, predicted not-taken, resolved taken target 0x200 with 4 younger entries -> redirect_valid = 1, redirect_pc = 0x200, bp_update = 1. Next cycle count = 0, empty = 1.
- JALR predicted 0x40, resolved 0x44 -> redirect_pc = 0x44, commit_dest/value written. Correct prediction -> redirect_valid stays 0.
- wb0 and wb1 same tag same cycle, values 1 and 2 -> stored value 1. rdy low 2 cycles -> no pointer or count change.
